pc_trace_buffer: RTL and testbench

Synthesisable program-counter trace unit that sits beside the pipeline CPU and samples the IF-stage PC every cycle. Keeps a circular history of the last DEPTH distinct PC values and classifies each step as sequential, stall or redirect. Raises a sticky flag when the PC is stuck. Provides the on-chip, parametrised replacement for printing PC values from a testbench, readable through the debug path.

---
 rtl/pc_trace_pkg.sv | 24 ++
 rtl/pc_trace_ram.sv | 44 ++++
 rtl/pc_trace_buffer.sv | 193 +++++++++++++++++++
 tb/tb_pc_trace_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_trace_pkg.sv
// Shared types and helpers for the PC trace unit.
// Optional alignment checking is enabled with PC_TRACE_ALIGN_CHECK_EN.
package pc_trace_pkg;

    localparam int unsigned REDIR_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        STALL = 2'd2
    } trace_state_e;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        REPEAT = 2'd1,
        REDIR  = 2'd2
    } step_cls_e;

    // Increment that sticks at limit.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] limit);
        return (val >= limit) ? limit : val + 32'd1;
    endfunction

endpackage

// File: rtl/pc_trace_ram.sv
// DEPTH x PC_W trace storage: synchronous write, registered read.
// The array has no reset; rvalid masks unwritten/out-of-range entries to 0.
module pc_trace_ram #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [PC_W-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    input  logic                       rvalid,
    output logic [PC_W-1:0]            rdata
);

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [PC_W-1:0] rdata_q;
    logic [PC_W-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (rvalid) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pc_trace_buffer.sv
// Circular IF-stage PC history with step classification and stall/redirect tracking.
// Define PC_TRACE_ALIGN_CHECK_EN to add the sticky misalign / misalign_pc outputs.
module pc_trace_buffer
    import pc_trace_pkg::*;
#(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned STEP        = 4,
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PC_W-1:0]            pc_in,
    input  logic                       pc_valid,
    input  logic                       freeze,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [PC_W-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       redirect,
    output logic [REDIR_CNT_W-1:0]     redirect_cnt,
    output logic                       stall_flag,
    output logic                       wrapped
`ifdef PC_TRACE_ALIGN_CHECK_EN
    ,
    output logic                       misalign,
    output logic [PC_W-1:0]            misalign_pc
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

    trace_state_e           state_q, state_d;
    step_cls_e              step_cls;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [PC_W-1:0]        last_pc_q, last_pc_d;
    logic [SW-1:0]          stall_cnt_q, stall_cnt_d;
    logic                   redirect_q, redirect_d;
    logic [REDIR_CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic                   stall_flag_q, stall_flag_d;
    logic                   wrapped_q, wrapped_d;
    logic                   accept;
    logic                   we;
    logic [AW-1:0]          raddr;
    logic                   rvalid;

    assign accept = pc_valid & ~freeze;

    always_comb begin
        step_cls = REDIR;
        if (pc_in == last_pc_q + PC_W'(STEP)) begin
            step_cls = SEQ;
        end else if (pc_in == last_pc_q) begin
            step_cls = REPEAT;
        end
    end

    // Next-state, classification side effects and write bookkeeping.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        last_pc_d      = last_pc_q;
        stall_cnt_d    = stall_cnt_q;
        redirect_d     = 1'b0;
        redirect_cnt_d = redirect_cnt_q;
        stall_flag_d   = stall_flag_q;
        wrapped_d      = wrapped_q;
        we             = 1'b0;

        if (accept) begin
            case (state_q)
                EMPTY: begin
                    we      = 1'b1;
                    state_d = TRACK;
                end
                default: begin
                    case (step_cls)
                        SEQ: begin
                            we           = 1'b1;
                            stall_cnt_d  = '0;
                            stall_flag_d = 1'b0;
                            state_d      = TRACK;
                        end
                        REPEAT: begin
                            stall_cnt_d = SW'(sat_inc(32'(stall_cnt_q), STALL_LIMIT));
                            if (stall_cnt_d == SW'(STALL_LIMIT)) begin
                                stall_flag_d = 1'b1;
                                state_d      = STALL;
                            end
                        end
                        default: begin
                            we             = 1'b1;
                            redirect_d     = 1'b1;
                            redirect_cnt_d = REDIR_CNT_W'(sat_inc(32'(redirect_cnt_q), 32'h0000_FFFF));
                            stall_cnt_d    = '0;
                            stall_flag_d   = 1'b0;
                            state_d        = TRACK;
                        end
                    endcase
                end
            endcase
        end

        if (we) begin
            last_pc_d = pc_in;
            wr_ptr_d  = wr_ptr_q + AW'(1);
            count_d   = CW'(sat_inc(32'(count_q), DEPTH));
            if (count_q == CW'(DEPTH)) begin
                wrapped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= EMPTY;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            last_pc_q      <= '0;
            stall_cnt_q    <= '0;
            redirect_q     <= 1'b0;
            redirect_cnt_q <= '0;
            stall_flag_q   <= 1'b0;
            wrapped_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            last_pc_q      <= last_pc_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_q     <= redirect_d;
            redirect_cnt_q <= redirect_cnt_d;
            stall_flag_q   <= stall_flag_d;
            wrapped_q      <= wrapped_d;
        end
    end

    // Newest entry sits just behind the write pointer; reads use pre-write pointer and count.
    assign raddr  = wr_ptr_q - AW'(1) - rd_idx;
    assign rvalid = CW'(rd_idx) < count_q;

    pc_trace_ram #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (wr_ptr_q),
        .wdata  (pc_in),
        .raddr  (raddr),
        .rvalid (rvalid),
        .rdata  (rd_data)
    );

    assign count        = count_q;
    assign redirect     = redirect_q;
    assign redirect_cnt = redirect_cnt_q;
    assign stall_flag   = stall_flag_q;
    assign wrapped      = wrapped_q;

`ifdef PC_TRACE_ALIGN_CHECK_EN
    logic            misalign_q, misalign_d;
    logic [PC_W-1:0] misalign_pc_q, misalign_pc_d;

    // Capture only the first misaligned sample.
    always_comb begin
        misalign_d    = misalign_q;
        misalign_pc_d = misalign_pc_q;
        if (accept && !misalign_q && (pc_in[1:0] != 2'b00)) begin
            misalign_d    = 1'b1;
            misalign_pc_d = pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q    <= 1'b0;
            misalign_pc_q <= '0;
        end else begin
            misalign_q    <= misalign_d;
            misalign_pc_q <= misalign_pc_d;
        end
    end

    assign misalign    = misalign_q;
    assign misalign_pc = misalign_pc_q;
`endif

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Scoreboard bench for pc_trace_buffer; a queue-based history model supplies expected values.
// Define PC_TRACE_ALIGN_CHECK_EN to also check the alignment outputs.
module tb_pc_trace_buffer;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned DEPTH       = 16;
    localparam int unsigned STEP        = 4;
    localparam int unsigned STALL_LIMIT = 8;
    localparam int unsigned AW          = 4;
    localparam int unsigned CW          = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [PC_W-1:0] pc_in = '0;
    logic            pc_valid = 1'b0;
    logic            freeze = 1'b0;
    logic [AW-1:0]   rd_idx = '0;
    logic [PC_W-1:0] rd_data;
    logic [CW-1:0]   count;
    logic            redirect;
    logic [15:0]     redirect_cnt;
    logic            stall_flag;
    logic            wrapped;
`ifdef PC_TRACE_ALIGN_CHECK_EN
    logic            misalign;
    logic [PC_W-1:0] misalign_pc;
`endif

    pc_trace_buffer #(
        .PC_W        (PC_W),
        .DEPTH       (DEPTH),
        .STEP        (STEP),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .pc_valid     (pc_valid),
        .freeze       (freeze),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .count        (count),
        .redirect     (redirect),
        .redirect_cnt (redirect_cnt),
        .stall_flag   (stall_flag),
        .wrapped      (wrapped)
`ifdef PC_TRACE_ALIGN_CHECK_EN
        ,
        .misalign     (misalign),
        .misalign_pc  (misalign_pc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            redirect;
        logic [CW-1:0]   count;
        logic [15:0]     rcnt;
        logic            stall;
        logic            wrapped;
        logic            mis;
        logic [PC_W-1:0] mis_pc;
    } exp_t;

    exp_t            exp_q[$];
    logic [PC_W-1:0] rd_exp_q[$];
    int unsigned     n_checks = 0;
    int unsigned     n_fail   = 0;

    // Reference model: newest PC at the front of hist.
    logic [PC_W-1:0] hist[$];
    bit              m_started;
    logic [PC_W-1:0] m_last;
    int unsigned     m_scnt;
    bit              m_sf;
    bit              m_wr;
    int unsigned     m_rc;
    bit              m_mis;
    logic [PC_W-1:0] m_mis_pc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_started = 0;
        m_last    = '0;
        m_scnt    = 0;
        m_sf      = 0;
        m_wr      = 0;
        m_rc      = 0;
        m_mis     = 0;
        m_mis_pc  = '0;
    endtask

    task automatic model_write(input logic [PC_W-1:0] pc);
        if (hist.size() == DEPTH) begin
            m_wr = 1;
            void'(hist.pop_back());
        end
        hist.push_front(pc);
        m_last = pc;
    endtask

    task automatic check_all_zero();
        check_eq("rst_rd_data",  64'(rd_data),      64'd0);
        check_eq("rst_count",    64'(count),        64'd0);
        check_eq("rst_redirect", 64'(redirect),     64'd0);
        check_eq("rst_rcnt",     64'(redirect_cnt), 64'd0);
        check_eq("rst_stall",    64'(stall_flag),   64'd0);
        check_eq("rst_wrapped",  64'(wrapped),      64'd0);
`ifdef PC_TRACE_ALIGN_CHECK_EN
        check_eq("rst_misalign", 64'(misalign),     64'd0);
        check_eq("rst_mis_pc",   64'(misalign_pc),  64'd0);
`endif
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        #1 rst = 1'b0;
        #1 check_all_zero();
        model_reset();
        exp_q.delete();
        rd_exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic step(input bit v, input logic [PC_W-1:0] pc, input bit frz);
        exp_t e;
        bit   redir;
        pc_valid = v;
        pc_in    = pc;
        freeze   = frz;
        redir    = 0;
        if (v && !frz) begin
            if ((pc[1:0] != 2'b00) && !m_mis) begin
                m_mis    = 1;
                m_mis_pc = pc;
            end
            if (!m_started) begin
                m_started = 1;
                model_write(pc);
            end else if (pc == m_last + PC_W'(STEP)) begin
                model_write(pc);
                m_scnt = 0;
                m_sf   = 0;
            end else if (pc == m_last) begin
                if (m_scnt < STALL_LIMIT) m_scnt++;
                if (m_scnt == STALL_LIMIT) m_sf = 1;
            end else begin
                model_write(pc);
                redir  = 1;
                m_scnt = 0;
                m_sf   = 0;
                if (m_rc < 32'hFFFF) m_rc++;
            end
        end
        e.redirect = redir;
        e.count    = CW'(hist.size());
        e.rcnt     = 16'(m_rc);
        e.stall    = m_sf;
        e.wrapped  = m_wr;
        e.mis      = m_mis;
        e.mis_pc   = m_mis_pc;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("redirect",     64'(redirect),     64'(e.redirect));
        check_eq("count",        64'(count),        64'(e.count));
        check_eq("redirect_cnt", 64'(redirect_cnt), 64'(e.rcnt));
        check_eq("stall_flag",   64'(stall_flag),   64'(e.stall));
        check_eq("wrapped",      64'(wrapped),      64'(e.wrapped));
`ifdef PC_TRACE_ALIGN_CHECK_EN
        check_eq("misalign",     64'(misalign),     64'(e.mis));
        check_eq("misalign_pc",  64'(misalign_pc),  64'(e.mis_pc));
`endif
    endtask

    task automatic rd_check(input int unsigned idx);
        logic [PC_W-1:0] exp;
        pc_valid = 1'b0;
        freeze   = 1'b0;
        rd_idx   = AW'(idx);
        exp      = (idx < hist.size()) ? hist[idx] : '0;
        rd_exp_q.push_back(exp);
        @(posedge clk);
        #1;
        exp = rd_exp_q.pop_front();
        check_eq($sformatf("rd_data[%0d]", idx), 64'(rd_data), 64'(exp));
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        do_reset();

        // Simple sequential fill plus out-of-range read.
        step(1, 32'h0, 0);
        step(1, 32'h4, 0);
        step(1, 32'h8, 0);
        check_eq("count_is_3", 64'(count), 64'd3);
        for (int i = 0; i < 4; i++) rd_check(i);

        // Redirect pulse and counter.
        do_reset();
        step(1, 32'h10, 0);
        step(1, 32'h14, 0);
        step(1, 32'h40, 0);
        check_eq("redirect_pulse", 64'(redirect), 64'd1);
        step(0, 32'h0, 0);
        check_eq("redirect_cnt_1", 64'(redirect_cnt), 64'd1);
        rd_check(0);

        // Stall detection and clearing.
        do_reset();
        step(1, 32'h1C, 0);
        for (int i = 0; i < 9; i++) step(1, 32'h20, 0);
        check_eq("stall_set", 64'(stall_flag), 64'd1);
        check_eq("stall_count", 64'(count), 64'd2);
        step(1, 32'h24, 0);
        check_eq("stall_clear", 64'(stall_flag), 64'd0);
        rd_check(0);
        rd_check(1);

        // Wrap-around with 20 sequential PCs.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, PC_W'(i * 4), 0);
        check_eq("wrap_count", 64'(count), 64'd16);
        check_eq("wrap_flag", 64'(wrapped), 64'd1);
        rd_check(15);
        rd_check(0);

        // Freeze ignores changing samples; last_pc must be preserved.
        step(1, 32'h100, 1);
        step(1, 32'h200, 1);
        step(1, 32'h300, 1);
        step(0, 32'h400, 0);
        step(1, 32'h50, 0);
        rd_check(0);
        rd_check(1);

        // Mid-stream asynchronous reset.
        do_reset();
        step(1, 32'h100, 0);
        step(1, 32'h200, 0);
        do_reset();
        step(1, 32'h300, 0);
        rd_check(0);

`ifdef PC_TRACE_ALIGN_CHECK_EN
        do_reset();
        step(1, 32'h0, 0);
        step(1, 32'h6, 0);
        step(1, 32'hA, 0);
        check_eq("misalign_set", 64'(misalign), 64'd1);
        check_eq("misalign_pc_6", 64'(misalign_pc), 64'h6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
